// File: rtl/itch_feed_arbiter.sv
// Message-granular round-robin arbiter sharing one ITCH parser byte stream between N_SRC feeds.
// A source keeps the grant for one whole length-prefixed message; bytes pass through combinationally.
module itch_feed_arbiter #(
  parameter int N_SRC = 2,
  parameter int SW    = (N_SRC > 2) ? $clog2(N_SRC) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [8*N_SRC-1:0] src_byte,
  input  logic [N_SRC-1:0]   src_valid,
  output logic [N_SRC-1:0]   src_ready,
  output logic [7:0]         out_byte,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [SW-1:0]      grant_id,
  output logic               busy,
  output logic               msg_done,
  output logic [31:0]        msg_count
);

  // state  | meaning
  // IDLE   | no grant; arbitrate among requesting sources
  // LEN_HI | pass length high byte
  // LEN_LO | pass length low byte, load remaining
  // TYPE   | pass message type byte
  // BODY   | pass remaining body bytes
  // DONE   | one-cycle gap, msg_done high
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LEN_HI = 3'd1;
  localparam logic [2:0] S_LEN_LO = 3'd2;
  localparam logic [2:0] S_TYPE   = 3'd3;
  localparam logic [2:0] S_BODY   = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  logic [2:0]    state_q, state_d;
  logic [SW-1:0] grant_q, grant_d;
  logic [SW-1:0] last_q, last_d;
  logic [7:0]    len_hi_q, len_hi_d;
  logic [15:0]   remaining_q, remaining_d;
  logic          msg_done_q, msg_done_d;
  logic [31:0]   msg_count_q, msg_count_d;

  logic          passthru;
  logic          xfer;
  logic [7:0]    sel_byte;
  logic          sel_valid;
  logic          pick_found;
  logic [SW-1:0] pick_id;
  logic [15:0]   len_full;

  always_comb begin
    sel_byte  = 8'h00;
    sel_valid = 1'b0;
    for (int i = 0; i < N_SRC; i++) begin
      if (grant_q == SW'(i)) begin
        sel_byte  = src_byte[8*i +: 8];
        sel_valid = src_valid[i];
      end
    end
  end

  // Scan from the farthest offset down so the nearest requester after last_q wins.
  always_comb begin
    pick_found = 1'b0;
    pick_id    = last_q;
    for (int k = N_SRC; k >= 1; k--) begin
      for (int i = 0; i < N_SRC; i++) begin
        if (src_valid[i] && (i == ((int'(last_q) + k) % N_SRC))) begin
          pick_found = 1'b1;
          pick_id    = SW'(i);
        end
      end
    end
  end

  assign passthru = (state_q == S_LEN_HI) || (state_q == S_LEN_LO) ||
                    (state_q == S_TYPE)   || (state_q == S_BODY);
  assign xfer     = passthru && sel_valid && out_ready;
  assign len_full = {len_hi_q, sel_byte};

  always_comb begin
    for (int i = 0; i < N_SRC; i++) begin
      src_ready[i] = passthru && out_ready && (grant_q == SW'(i));
    end
  end

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    last_d      = last_q;
    len_hi_d    = len_hi_q;
    remaining_d = remaining_q;
    msg_done_d  = 1'b0;
    msg_count_d = msg_count_q;
    case (state_q)
      S_IDLE: begin
        if (pick_found) begin
          grant_d = pick_id;
          last_d  = pick_id;
          state_d = S_LEN_HI;
        end
      end
      S_LEN_HI: begin
        if (xfer) begin
          len_hi_d = sel_byte;
          state_d  = S_LEN_LO;
        end
      end
      S_LEN_LO: begin
        if (xfer) begin
          remaining_d = (len_full < 16'd3) ? 16'd0 : (len_full - 16'd3);
          state_d     = S_TYPE;
        end
      end
      S_TYPE: begin
        if (xfer) begin
          if (remaining_q != 16'd0) begin
            state_d = S_BODY;
          end else begin
            state_d     = S_DONE;
            msg_done_d  = 1'b1;
            msg_count_d = msg_count_q + 32'd1;
          end
        end
      end
      S_BODY: begin
        if (xfer) begin
          remaining_d = remaining_q - 16'd1;
          if (remaining_q == 16'd1) begin
            state_d     = S_DONE;
            msg_done_d  = 1'b1;
            msg_count_d = msg_count_q + 32'd1;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      grant_q     <= '0;
      last_q      <= SW'(N_SRC - 1);
      len_hi_q    <= 8'h00;
      remaining_q <= 16'h0000;
      msg_done_q  <= 1'b0;
      msg_count_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      last_q      <= last_d;
      len_hi_q    <= len_hi_d;
      remaining_q <= remaining_d;
      msg_done_q  <= msg_done_d;
      msg_count_q <= msg_count_d;
    end
  end

  assign out_byte  = passthru ? sel_byte : 8'h00;
  assign out_valid = passthru && sel_valid;
  assign grant_id  = grant_q;
  assign busy      = passthru;
  assign msg_done  = msg_done_q;
  assign msg_count = msg_count_q;

endmodule

// File: doc/itch_feed_arbiter.md
# itch_feed_arbiter

Message-granular round-robin arbiter that shares the single ITCH `parser` byte input between `N_SRC` upstream feed sources. A source is granted for exactly one whole length-prefixed message, which passes through with zero latency. The grant is then released and re-arbitrated, so the parser never sees bytes of two messages interleaved. The block sits between the feed receivers and `parser.in_byte/in_valid/in_ready`.

## Interface

Parameters:
- `N_SRC`, default 2: number of sources, range 2..4.
- `SW`, default `$clog2(N_SRC)`: grant index width (minimum 1).

Ports:
- `clk` in 1: single clock.
- `rst` in 1: synchronous reset, active-high.
- `src_byte` in 8*N_SRC: source i byte on bits [8i+7:8i].
- `src_valid` in N_SRC: per-source byte valid.
- `src_ready` out N_SRC: per-source byte accepted.
- `out_byte` out 8: byte to parser.
- `out_valid` out 1: byte valid to parser.
- `out_ready` in 1: parser `in_ready`.
- `grant_id` out SW: currently or last granted source.
- `busy` out 1: a message is in flight.
- `msg_done` out 1: one-cycle pulse registered after the final byte of a message transfers.
- `msg_count` out 32: total messages forwarded, wraps at 2^32.

## Operation

- Framing:
  - Bytes 0 and 1 of a message are the length L, big-endian (byte 0 = high).
  - L counts the whole message, including the two length bytes and the type byte.
  - Message ends after L bytes have transferred.
  - L < 3 is treated as L = 3.
- A byte transfers on a cycle where `out_valid && out_ready`.
- States:
  - IDLE
    - No transfer occurs. `busy` = 0; all `src_ready` = 0; `out_valid` = 0.
    - If any `src_valid` is high, pick the first asserted source scanning from `last+1` modulo N_SRC.
    - Register `grant_id` and `last` to that source, then go to LEN_HI.
  - LEN_HI: on transfer, capture the high length byte, then go to LEN_LO.
  - LEN_LO: on transfer, compute `remaining = max(L,3) - 3` (the type byte is still to come) and go to TYPE.
  - TYPE: on transfer, go to BODY if `remaining != 0`, else DONE.
  - BODY: on each transfer, decrement `remaining`; the transfer that takes it from 1 to 0 goes to DONE.
  - DONE (one cycle):
    - No transfer occurs. `msg_done` = 1; `msg_count` increments; `busy` = 0.
    - Next state is IDLE.
- Passthrough in every non-IDLE/DONE state is purely combinational:
  - `out_byte` = `src_byte[grant_id]`; `out_valid` = `src_valid[grant_id]`.
  - `src_ready[grant_id]` = `out_ready`; all other `src_ready` = 0.
- Non-granted sources are never accepted mid-message, regardless of their `src_valid`.
- A stalled granted source (`src_valid` low) holds the grant indefinitely. There is no timeout.
- `remaining` is 16 bits; the maximum L is 65535 and needs no overflow handling.

## Timing

- Reset values:
  - state = IDLE; `last` = N_SRC-1, so source 0 wins first.
  - `grant_id` = 0; `busy` = 0; `msg_done` = 0; `msg_count` = 0.
  - `out_valid` = 0; all `src_ready` = 0.
- Reset asserted mid-message abandons the message immediately. `src_ready` and `out_valid` are 0 on the cycle after `rst` is sampled high.
- Latency:
  - Zero cycles byte-path latency.
  - 1 cycle of arbitration (IDLE) before the first byte.
  - 1 cycle (DONE) after the last byte.
  - Minimum gap between consecutive messages is 2 cycles with no transfer.
- Throughput: one byte per cycle while granted, the source is valid and the parser is ready.
- `src_valid` may be asserted in IDLE; only the grant winner's byte is presented starting the next cycle. Its `src_valid` must be held until accepted.
- Simultaneous requests from all sources in IDLE: round-robin from `last+1`. Each source gets at most one message before every other waiting source gets one.
- `out_ready` low stalls the transfer; state and `remaining` are held.

## Test plan

- Single message, L = 0x0014, on src0 with `out_ready` = 1:
  - The 20 bytes appear on `out_byte` on 20 consecutive cycles starting the cycle after `src_valid` rises.
  - `msg_done` pulses once; `msg_count` = 1.
- Both sources continuously request 3 messages each of L = 5:
  - Grant order is 0,1,0,1,0,1.
  - No interleaving within a message.
  - Exactly 2 transfer-free cycles between messages; `msg_count` = 6.
- Parser backpressure: `out_ready` toggles 1,0,0,1 during the BODY of an L = 8 message:
  - No byte is lost or duplicated.
  - `src_ready` of the non-granted source stays 0 throughout.
- Short and edge lengths, in separate runs:
  - L = 0x0002 → message treated as 3 bytes, next message grant follows.
  - L = 0x0003 → TYPE→DONE with no BODY.
- Reset asserted on byte 6 of an L = 20 message:
  - All outputs return to reset values on the next cycle.
  - After release, src0 is granted first and a fresh L = 5 message forwards correctly.
- Granted src1 deasserts `src_valid` for 50 cycles mid-body while src0 requests:
  - src1 keeps the grant; src0 is not accepted until src1's message completes.
